// File: rtl/adder_rr_sched_if.sv
// Requester-side bundle for adder_rr_sched.
// master: the requesting clients drive the operations and take back the results.
// slave : the scheduler grants requests and returns the results.
//   req_valid/req_ready : per-requester handshake, one-hot ready
//   req_a/req_b/req_sub : packed operands, slice i = [i*BIT +: BIT]; sub 1 = subtract
//   rsp_valid           : one-hot 1-cycle result strobe
//   rsp_sum/rsp_cout    : shared result bus
interface adder_rr_sched_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned BIT  = 3
);
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*BIT-1:0] req_a;
   logic [NREQ*BIT-1:0] req_b;
   logic [NREQ-1:0]     req_sub;
   logic [NREQ-1:0]     rsp_valid;
   logic [BIT-1:0]      rsp_sum;
   logic                rsp_cout;

   modport master (
      output req_valid, req_a, req_b, req_sub,
      input  req_ready, rsp_valid, rsp_sum, rsp_cout
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub,
      output req_ready, rsp_valid, rsp_sum, rsp_cout
   );
endinterface

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one pipelined adder (BIT+1 cycle latency) among
// NREQ requesters. One operation accepted per cycle; results are routed back to
// the originating requester through a tag pipeline matched to the adder latency.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   bus           : requester bundle (slave side)
//   inflight      : accepted operations not yet responded
//   adder_nrst    : registered ~rst to the adder
//   adder_addsub, adder_a, adder_b : registered issue operands to the adder
//   adder_sum, adder_cout          : adder results, aligned with the tag tail
module adder_rr_sched #(
   parameter int unsigned BIT  = 3,
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   adder_rr_sched_if.slave       bus,
   output logic [3:0]            inflight,
   output logic                  adder_nrst,
   output logic                  adder_addsub,
   output logic [BIT-1:0]        adder_a,
   output logic [BIT-1:0]        adder_b,
   input  logic [BIT-1:0]        adder_sum,
   input  logic                  adder_cout
);

   logic [IDW-1:0]  ptr_q;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic            found;
   logic [IDW:0]    cand_sum;
   logic [IDW-1:0]  cand;
   logic            accept;
   logic [BIT-1:0]  win_a;
   logic [BIT-1:0]  win_b;
   logic            win_sub;
   logic [IDW-1:0]  ptr_next;

   logic            issue_valid;
   logic [IDW-1:0]  issue_id;
   logic [BIT:0]    tag_v;
   logic [IDW-1:0]  tag_id [BIT+1];
   logic            resp;
   logic [3:0]      count_q;

   // Search from the pointer upward, wrapping modulo NREQ; first valid wins.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      cand_sum = '0;
      cand     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand_sum >= (IDW+1)'(NREQ)) begin
            cand_sum = cand_sum - (IDW+1)'(NREQ);
         end
         cand = cand_sum[IDW-1:0];
         if (!found && bus.req_valid[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_id    = cand;
         end
      end
      if (rst) begin
         grant = '0;
      end
   end

   assign bus.req_ready = grant;
   assign accept        = |grant;

   always_comb begin
      win_a   = '0;
      win_b   = '0;
      win_sub = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant[i]) begin
            win_a   = bus.req_a[i*BIT +: BIT];
            win_b   = bus.req_b[i*BIT +: BIT];
            win_sub = bus.req_sub[i];
         end
      end
   end

   assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk) begin
      adder_nrst <= ~rst;
      if (rst) begin
         ptr_q        <= '0;
         adder_a      <= '0;
         adder_b      <= '0;
         adder_addsub <= 1'b0;
         issue_valid  <= 1'b0;
         issue_id     <= '0;
      end else begin
         issue_valid <= accept;
         if (accept) begin
            ptr_q        <= ptr_next;
            adder_a      <= win_a;
            adder_b      <= win_b;
            adder_addsub <= win_sub;
            issue_id     <= grant_id;
         end
      end
   end

   // Tag pipe: BIT+1 stages so the tail lines up with the adder output.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
      end else begin
         tag_v <= {tag_v[BIT-1:0], issue_valid};
      end
      tag_id[0] <= issue_id;
      for (int i = 1; i <= int'(BIT); i++) begin
         tag_id[i] <= tag_id[i-1];
      end
   end

   // Reset masks the tail so tags about to retire during reset never respond.
   assign resp = tag_v[BIT] & ~rst;

   always_comb begin
      bus.rsp_valid = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         bus.rsp_valid[i] = resp && (tag_id[BIT] == IDW'(i));
      end
      bus.rsp_sum  = adder_sum;
      bus.rsp_cout = adder_cout;
   end

   // Output reflects this cycle's accept/response, so a lone op reads 1 from its
   // acceptance cycle until its response cycle.
   assign inflight = rst ? 4'd0 : count_q + 4'(accept) - 4'(resp);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= inflight;
      end
   end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Round-robin scheduler that time-shares one pipelined `adder` instance (BIT-wide, fixed BIT+1-cycle internal latency, no stall) among NREQ requesters.
- Accepts at most one add/sub operation per cycle and registers operands into the adder.
- Tracks each in-flight operation with a tag pipeline matched to the adder latency.
- Routes SUM/cout back to the originating requester with a one-hot response strobe.
- Sits between the requesting datapath clients and the shared adder; the adder is instantiated by the parent and wired to the adder_* ports.

Parameters:
- BIT, 3, operand width; must match the connected adder.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester index width = clog2(NREQ).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  one-hot grant; accept when req_valid[i] & req_ready[i].
- req_a  input  NREQ*BIT  packed operand A; slice i = bits [i*BIT +: BIT].
- req_b  input  NREQ*BIT  packed operand B.
- req_sub  input  NREQ  per-requester op: 0 add, 1 subtract.
- rsp_valid  output  NREQ  one-hot, 1-cycle result strobe to the originating requester.
- rsp_sum  output  BIT  result, shared by all requesters.
- rsp_cout  output  1  carry-out, shared.
- inflight  output  4  number of accepted operations not yet responded (0..BIT+2).
- adder_nrst  output  1  to adder nrst; registered ~rst.
- adder_addsub  output  1  to adder addsub.
- adder_a  output  BIT  to adder A.
- adder_b  output  BIT  to adder B.
- adder_sum  input  BIT  from adder SUM.
- adder_cout  input  1  from adder cout.

Behaviour:
- Reset (rst high at a clk edge):
  - issue regs cleared: adder_a=0, adder_b=0, adder_addsub=0, issue_valid=0.
  - rr pointer = 0; tag pipeline all invalid; inflight=0; adder_nrst=0.
- Reset release: adder_nrst rises at the first edge with rst low. Requests are accepted from the cycle after rst deasserts. Operands issued while adder_nrst is still low are harmless; the tag pipeline carries no valid for them.
- Arbitration (combinational):
  - Search req_valid starting at the rr pointer, ascending and wrapping modulo NREQ.
  - The first set bit wins; req_ready is one-hot on the winner, all zero if none valid or rst high.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Pointer update: on acceptance of requester g, the pointer becomes (g+1) mod NREQ. It is unchanged when nothing is accepted.
- Issue stage: on acceptance, register the winner's a, b and sub into adder_a/adder_b/adder_addsub. Set issue_valid=1 and issue_id=g. With no acceptance, set issue_valid=0; operand regs may hold their values.
- Tag pipeline:
  - Shift register of {valid, id}, depth BIT+1, fed from issue_valid/issue_id, advancing every cycle with no stall.
  - Its output aligns with adder_sum/adder_cout.
- Latency: operation accepted in cycle t gives rsp_valid[id]=1, rsp_sum=adder_sum and rsp_cout=adder_cout in cycle t+BIT+2 (t+5 at BIT=3). All of rsp_* are combinational from the tag-pipe tail and the adder outputs.
- Throughput: one operation per cycle sustained. Responses return in acceptance order. There is no response backpressure; requesters must take rsp_valid when it is asserted.
- rsp_sum/rsp_cout values are don't-care when rsp_valid=0.
- inflight: increments on acceptance, decrements on response, unchanged when both happen in the same cycle.
- Arithmetic: performed by the adder.
  - Subtract is A + ((~B+1) mod 2^BIT), so B=0 subtract gives B term 0.
  - rsp_cout is the raw adder carry; no borrow inversion.
- Reset mid-operation: all in-flight tags are dropped; no rsp_valid for them after reset, ever. inflight returns to 0.
- Simultaneous events:
  - Acceptance and response for the same requester in the same cycle are both legal.
  - A requester may have up to BIT+2 operations outstanding.

Test Plan:
- Single add, BIT=3: req 1 sends a=3, b=2, sub=0, accepted in cycle t → rsp_valid=0010 only in cycle t+5, rsp_sum=5, rsp_cout=0. inflight is 1 through cycle t+4, then 0.
- Subtract carry cases:
  - req 0, a=3, b=2, sub=1 → sum=1, cout=1.
  - req 0, a=2, b=3, sub=1 → sum=7, cout=0.
  - req 0, a=7, b=1, sub=0 → sum=0, cout=1.
- Round-robin fairness: all four req_valid held high for 8 cycles from pointer 0 → grants 0,1,2,3,0,1,2,3 on consecutive cycles. rsp_valid follows the same order, 5 cycles later, one per cycle; inflight saturates at 5.
- Pointer skip: only req 2 and req 0 valid, pointer=1 → req 2 granted first, then req 0, pointer=1 after. Idle cycles leave the pointer unchanged.
- Reset mid-flight: accept 3 ops on consecutive cycles, assert rst for 1 cycle 2 cycles later → no rsp_valid afterwards, inflight=0, adder_nrst low for exactly 1 cycle. A new op after release returns its correct result 5 cycles after acceptance.
- Back-to-back same requester: req 3 issues 1+1, 2+2, 3+3 consecutively → rsp_valid[3] on 3 consecutive cycles with sums 2, 4, 6.
